// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the RV32I core.
// Decodes the ALU control code, picks operands through two bypass ports and
// registers the execute-stage bundle under flush > stall > load priority.
module id_ex_stage #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_5,
   input  logic [WIDTH-1:0] pc,
   input  logic [WIDTH-1:0] imm,
   input  logic [4:0]       rs1_addr,
   input  logic [4:0]       rs2_addr,
   input  logic [4:0]       rd_addr,
   input  logic [WIDTH-1:0] rs1_data,
   input  logic [WIDTH-1:0] rs2_data,
   input  logic             fwd1_we,
   input  logic             fwd2_we,
   input  logic [4:0]       fwd1_rd,
   input  logic [4:0]       fwd2_rd,
   input  logic [WIDTH-1:0] fwd1_data,
   input  logic [WIDTH-1:0] fwd2_data,
   output logic             ex_valid,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] ex_store_data,
   output logic [4:0]       ex_rd,
   output logic             ex_regwrite,
   output logic             ex_branch,
   output logic [2:0]       ex_funct3,
   output logic             ex_illegal
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SLL  = 4'b0001,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b1101
   } alu_ctrl_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // Everything the execute stage sees, registered as one bundle so that a
   // bubble is simply the all-zero value (ALU_ADD is 0000).
   typedef struct packed {
      logic             valid;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      alu_ctrl_e        ctrl;
      logic [WIDTH-1:0] store;
      logic [4:0]       rd;
      logic             regwrite;
      logic             branch;
      logic [2:0]       funct3;
      logic             illegal;
   } ex_bundle_t;

   logic [WIDTH-1:0] w_rs1_val;
   logic [WIDTH-1:0] w_rs2_val;
   ex_bundle_t       w_dec;
   ex_bundle_t       r_ex;

   // Register/immediate ALU op from funct3; alt selects SUB/SRA.
   function automatic alu_ctrl_e alu_from_funct3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_from_funct3 = ALU_SLL;
         3'b010:  alu_from_funct3 = ALU_SLT;
         3'b011:  alu_from_funct3 = ALU_SLTU;
         3'b100:  alu_from_funct3 = ALU_XOR;
         3'b101:  alu_from_funct3 = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_from_funct3 = ALU_OR;
         default: alu_from_funct3 = ALU_AND;
      endcase
   endfunction

   // fwd1 is the younger producer, so it wins over fwd2; x0 is never bypassed.
   assign w_rs1_val = (fwd1_we && (fwd1_rd == rs1_addr) && (rs1_addr != 5'd0)) ? fwd1_data :
                      (fwd2_we && (fwd2_rd == rs1_addr) && (rs1_addr != 5'd0)) ? fwd2_data :
                      rs1_data;
   assign w_rs2_val = (fwd1_we && (fwd1_rd == rs2_addr) && (rs2_addr != 5'd0)) ? fwd1_data :
                      (fwd2_we && (fwd2_rd == rs2_addr) && (rs2_addr != 5'd0)) ? fwd2_data :
                      rs2_data;

   // Decode the incoming instruction into the execute-stage bundle.
   always_comb begin
      // NOTE: every field gets a default first so no path through the case leaves a latch.
      w_dec          = '0;
      w_dec.valid    = 1'b1;
      w_dec.ctrl     = ALU_ADD;
      w_dec.store    = w_rs2_val;
      w_dec.rd       = rd_addr;
      w_dec.funct3   = funct3;
      case (opcode)
         OPC_OP: begin
            w_dec.ctrl     = alu_from_funct3(funct3, funct7_5);
            w_dec.a        = w_rs1_val;
            w_dec.b        = w_rs2_val;
            w_dec.regwrite = 1'b1;
         end
         OPC_OP_IMM: begin
            w_dec.ctrl     = alu_from_funct3(funct3, funct7_5 && (funct3 == 3'b101));
            w_dec.a        = w_rs1_val;
            w_dec.b        = imm;
            w_dec.regwrite = 1'b1;
         end
         OPC_LOAD: begin
            w_dec.a        = w_rs1_val;
            w_dec.b        = imm;
            w_dec.regwrite = 1'b1;
         end
         OPC_STORE: begin
            w_dec.a        = w_rs1_val;
            w_dec.b        = imm;
         end
         OPC_BRANCH: begin
            case (funct3)
               3'b000, 3'b001: w_dec.ctrl = ALU_SUB;
               3'b100, 3'b101: w_dec.ctrl = ALU_SLT;
               3'b110, 3'b111: w_dec.ctrl = ALU_SLTU;
               default:        w_dec.illegal = 1'b1;
            endcase
            if (!w_dec.illegal) begin
               w_dec.a      = w_rs1_val;
               w_dec.b      = w_rs2_val;
               w_dec.branch = 1'b1;
            end
         end
         OPC_LUI: begin
            w_dec.b        = imm;
            w_dec.regwrite = 1'b1;
         end
         OPC_AUIPC: begin
            w_dec.a        = pc;
            w_dec.b        = imm;
            w_dec.regwrite = 1'b1;
         end
         OPC_JAL, OPC_JALR: begin
            w_dec.a        = pc;
            w_dec.b        = WIDTH'(4);
            w_dec.regwrite = 1'b1;
         end
         default: w_dec.illegal = 1'b1;
      endcase
      if (rd_addr == 5'd0) w_dec.regwrite = 1'b0;
   end

   // Pipeline register: reset/flush/bubble clear, stall holds, otherwise load.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      if (reset)           r_ex <= '0;
      else if (flush)      r_ex <= '0;
      else if (!stall)     r_ex <= id_valid ? w_dec : '0;
   end

   assign ex_valid      = r_ex.valid;
   assign alu_a         = r_ex.a;
   assign alu_b         = r_ex.b;
   assign alu_ctrl      = r_ex.ctrl;
   assign ex_store_data = r_ex.store;
   assign ex_rd         = r_ex.rd;
   assign ex_regwrite   = r_ex.regwrite;
   assign ex_branch     = r_ex.branch;
   assign ex_funct3     = r_ex.funct3;
   assign ex_illegal    = r_ex.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: table-driven directed vectors for id_ex_stage plus
// hand-written reset / stall / flush sequences.
module tb_id_ex_stage;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, stall, flush, id_valid;
   logic [6:0]    opcode;
   logic [2:0]    funct3;
   logic          funct7_5;
   logic [W-1:0]  pc, imm, rs1_data, rs2_data, fwd1_data, fwd2_data;
   logic [4:0]    rs1_addr, rs2_addr, rd_addr, fwd1_rd, fwd2_rd;
   logic          fwd1_we, fwd2_we;
   logic          ex_valid, ex_regwrite, ex_branch, ex_illegal;
   logic [W-1:0]  alu_a, alu_b, ex_store_data;
   logic [3:0]    alu_ctrl;
   logic [4:0]    ex_rd;
   logic [2:0]    ex_funct3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
      .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .pc(pc), .imm(imm),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .fwd1_we(fwd1_we), .fwd2_we(fwd2_we), .fwd1_rd(fwd1_rd), .fwd2_rd(fwd2_rd),
      .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
      .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
      .ex_branch(ex_branch), .ex_funct3(ex_funct3), .ex_illegal(ex_illegal)
   );

   typedef struct packed {
      logic         valid;
      logic [6:0]   opcode;
      logic [2:0]   funct3;
      logic         f7;
      logic [W-1:0] pc, imm;
      logic [4:0]   rs1a;
      logic [W-1:0] rs1d;
      logic [4:0]   rs2a;
      logic [W-1:0] rs2d;
      logic [4:0]   rd;
      logic         f1we;
      logic [4:0]   f1rd;
      logic [W-1:0] f1d;
      logic         f2we;
      logic [4:0]   f2rd;
      logic [W-1:0] f2d;
   } in_t;

   typedef struct packed {
      logic         valid;
      logic [W-1:0] a, b;
      logic [3:0]   ctrl;
      logic [W-1:0] store;
      logic [4:0]   rd;
      logic         rw, br;
      logic [2:0]   f3;
      logic         ill;
   } exp_t;

   typedef struct packed {
      in_t  i;
      exp_t e;
   } vec_t;

   localparam logic [6:0] OP = 7'b0110011, OPI = 7'b0010011, LD = 7'b0000011,
                          ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111,
                          AUI = 7'b0010111, JAL = 7'b1101111, BAD = 7'b1111111;

   vec_t vecs[$];

   function automatic in_t mk_in(logic [6:0] op, logic [2:0] f3, logic f7, logic [W-1:0] p,
                                 logic [W-1:0] im, logic [4:0] r1a, logic [W-1:0] r1d,
                                 logic [4:0] r2a, logic [W-1:0] r2d, logic [4:0] rd);
      in_t t = '0;
      t.valid = 1'b1; t.opcode = op; t.funct3 = f3; t.f7 = f7; t.pc = p; t.imm = im;
      t.rs1a = r1a; t.rs1d = r1d; t.rs2a = r2a; t.rs2d = r2d; t.rd = rd;
      return t;
   endfunction

   function automatic exp_t mk_exp(logic v, logic [W-1:0] a, logic [W-1:0] b, logic [3:0] c,
                                   logic [W-1:0] s, logic [4:0] rd, logic rw, logic br,
                                   logic [2:0] f3, logic ill);
      exp_t e;
      e.valid = v; e.a = a; e.b = b; e.ctrl = c; e.store = s; e.rd = rd;
      e.rw = rw; e.br = br; e.f3 = f3; e.ill = ill;
      return e;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, ".ex_valid"},      W'(ex_valid),    W'(e.valid));
      check({tag, ".alu_a"},         alu_a,           e.a);
      check({tag, ".alu_b"},         alu_b,           e.b);
      check({tag, ".alu_ctrl"},      W'(alu_ctrl),    W'(e.ctrl));
      check({tag, ".ex_store_data"}, ex_store_data,   e.store);
      check({tag, ".ex_rd"},         W'(ex_rd),       W'(e.rd));
      check({tag, ".ex_regwrite"},   W'(ex_regwrite), W'(e.rw));
      check({tag, ".ex_branch"},     W'(ex_branch),   W'(e.br));
      check({tag, ".ex_funct3"},     W'(ex_funct3),   W'(e.f3));
      check({tag, ".ex_illegal"},    W'(ex_illegal),  W'(e.ill));
   endtask

   task automatic drive(input in_t t);
      id_valid = t.valid; opcode = t.opcode; funct3 = t.funct3; funct7_5 = t.f7;
      pc = t.pc; imm = t.imm; rs1_addr = t.rs1a; rs1_data = t.rs1d;
      rs2_addr = t.rs2a; rs2_data = t.rs2d; rd_addr = t.rd;
      fwd1_we = t.f1we; fwd1_rd = t.f1rd; fwd1_data = t.f1d;
      fwd2_we = t.f2we; fwd2_rd = t.f2rd; fwd2_data = t.f2d;
   endtask

   // Drive at the falling edge, sample 1 time unit after the rising edge.
   task automatic apply(input in_t t);
      @(negedge clk);
      drive(t);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      in_t  t;
      exp_t zero_e = '0;

      reset = 1'b1; stall = 1'b0; flush = 1'b0;
      drive(mk_in(OP, 3'b000, 1'b0, 32'h0, 32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3));
      #12;
      check_all("reset_initial", zero_e);
      @(negedge clk);
      reset = 1'b0;

      // ---- vector table ----
      vecs.push_back('{mk_in(OP, 3'b000, 1'b0, 32'h0, 32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3),
                       mk_exp(1, 32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1, 0, 3'b000, 0)});
      vecs.push_back('{mk_in(OP, 3'b000, 1'b1, 32'h0, 32'h0, 5'd1, 32'd20, 5'd2, 32'd6, 5'd4),
                       mk_exp(1, 32'd20, 32'd6, 4'b1000, 32'd6, 5'd4, 1, 0, 3'b000, 0)});
      vecs.push_back('{mk_in(OPI, 3'b101, 1'b1, 32'h0, 32'd3, 5'd5, 32'h80, 5'd3, 32'h11, 5'd6),
                       mk_exp(1, 32'h80, 32'd3, 4'b1101, 32'h11, 5'd6, 1, 0, 3'b101, 0)});
      vecs.push_back('{mk_in(OPI, 3'b000, 1'b1, 32'h0, 32'h10, 5'd1, 32'd1, 5'd0, 32'd0, 5'd7),
                       mk_exp(1, 32'd1, 32'h10, 4'b0000, 32'd0, 5'd7, 1, 0, 3'b000, 0)});
      vecs.push_back('{mk_in(BR, 3'b110, 1'b0, 32'h0, 32'h20, 5'd1, 32'd3, 5'd2, 32'd9, 5'd8),
                       mk_exp(1, 32'd3, 32'd9, 4'b0011, 32'd9, 5'd8, 0, 1, 3'b110, 0)});
      vecs.push_back('{mk_in(BR, 3'b000, 1'b0, 32'h0, 32'h8, 5'd1, 32'd4, 5'd2, 32'd4, 5'd0),
                       mk_exp(1, 32'd4, 32'd4, 4'b1000, 32'd4, 5'd0, 0, 1, 3'b000, 0)});
      vecs.push_back('{mk_in(BR, 3'b101, 1'b0, 32'h0, 32'h8, 5'd1, 32'd2, 5'd2, 32'd1, 5'd1),
                       mk_exp(1, 32'd2, 32'd1, 4'b0010, 32'd1, 5'd1, 0, 1, 3'b101, 0)});
      vecs.push_back('{mk_in(LUI, 3'b000, 1'b0, 32'h0, 32'h12345000, 5'd9, 32'hDEAD, 5'd0, 32'd0, 5'd7),
                       mk_exp(1, 32'd0, 32'h12345000, 4'b0000, 32'd0, 5'd7, 1, 0, 3'b000, 0)});
      vecs.push_back('{mk_in(AUI, 3'b000, 1'b0, 32'h200, 32'h3000, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2),
                       mk_exp(1, 32'h200, 32'h3000, 4'b0000, 32'd0, 5'd2, 1, 0, 3'b000, 0)});
      vecs.push_back('{mk_in(JAL, 3'b000, 1'b0, 32'h100, 32'h40, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1),
                       mk_exp(1, 32'h100, 32'd4, 4'b0000, 32'd0, 5'd1, 1, 0, 3'b000, 0)});
      vecs.push_back('{mk_in(JAL, 3'b000, 1'b0, 32'h100, 32'h40, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0),
                       mk_exp(1, 32'h100, 32'd4, 4'b0000, 32'd0, 5'd0, 0, 0, 3'b000, 0)});
      vecs.push_back('{mk_in(LD, 3'b010, 1'b0, 32'h0, 32'd8, 5'd1, 32'h1000, 5'd0, 32'd0, 5'd5),
                       mk_exp(1, 32'h1000, 32'd8, 4'b0000, 32'd0, 5'd5, 1, 0, 3'b010, 0)});
      vecs.push_back('{mk_in(ST, 3'b010, 1'b0, 32'h0, 32'd4, 5'd1, 32'h2000, 5'd2, 32'hCAFE, 5'd4),
                       mk_exp(1, 32'h2000, 32'd4, 4'b0000, 32'hCAFE, 5'd4, 0, 0, 3'b010, 0)});
      vecs.push_back('{mk_in(OP, 3'b101, 1'b0, 32'h0, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3),
                       mk_exp(1, 32'd1, 32'd2, 4'b0101, 32'd2, 5'd3, 1, 0, 3'b101, 0)});
      vecs.push_back('{mk_in(OP, 3'b011, 1'b0, 32'h0, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3),
                       mk_exp(1, 32'd1, 32'd2, 4'b0011, 32'd2, 5'd3, 1, 0, 3'b011, 0)});
      vecs.push_back('{mk_in(OP, 3'b001, 1'b0, 32'h0, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3),
                       mk_exp(1, 32'd1, 32'd2, 4'b0001, 32'd2, 5'd3, 1, 0, 3'b001, 0)});
      vecs.push_back('{mk_in(OP, 3'b100, 1'b0, 32'h0, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3),
                       mk_exp(1, 32'd1, 32'd2, 4'b0100, 32'd2, 5'd3, 1, 0, 3'b100, 0)});
      vecs.push_back('{mk_in(OP, 3'b111, 1'b0, 32'h0, 32'h0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3),
                       mk_exp(1, 32'd1, 32'd2, 4'b0111, 32'd2, 5'd3, 1, 0, 3'b111, 0)});
      vecs.push_back('{mk_in(OPI, 3'b110, 1'b1, 32'h0, 32'h0F, 5'd1, 32'd1, 5'd15, 32'd0, 5'd3),
                       mk_exp(1, 32'd1, 32'h0F, 4'b0110, 32'd0, 5'd3, 1, 0, 3'b110, 0)});
      vecs.push_back('{mk_in(OPI, 3'b010, 1'b0, 32'h0, 32'h5, 5'd1, 32'd9, 5'd5, 32'd0, 5'd3),
                       mk_exp(1, 32'd9, 32'h5, 4'b0010, 32'd0, 5'd3, 1, 0, 3'b010, 0)});
      // Bypass: both ports hit rs1=x3, fwd1 (younger) wins.
      t = mk_in(OP, 3'b000, 1'b0, 32'h0, 32'h0, 5'd3, 32'h1111, 5'd2, 32'd7, 5'd6);
      t.f1we = 1; t.f1rd = 5'd3; t.f1d = 32'hAAAA; t.f2we = 1; t.f2rd = 5'd3; t.f2d = 32'hBBBB;
      vecs.push_back('{t, mk_exp(1, 32'hAAAA, 32'd7, 4'b0000, 32'd7, 5'd6, 1, 0, 3'b000, 0)});
      // Only fwd2 targets x3; fwd1 writes an unrelated register.
      t.f1we = 1; t.f1rd = 5'd9;
      vecs.push_back('{t, mk_exp(1, 32'hBBBB, 32'd7, 4'b0000, 32'd7, 5'd6, 1, 0, 3'b000, 0)});
      // x0 is never bypassed.
      t = mk_in(OP, 3'b000, 1'b0, 32'h0, 32'h0, 5'd0, 32'h55, 5'd2, 32'd7, 5'd6);
      t.f1we = 1; t.f1rd = 5'd0; t.f1d = 32'h99;
      vecs.push_back('{t, mk_exp(1, 32'h55, 32'd7, 4'b0000, 32'd7, 5'd6, 1, 0, 3'b000, 0)});
      // rs2 bypass also feeds store data.
      t = mk_in(ST, 3'b010, 1'b0, 32'h0, 32'd12, 5'd1, 32'h40, 5'd4, 32'd1, 5'd0);
      t.f1we = 1; t.f1rd = 5'd4; t.f1d = 32'h1234;
      vecs.push_back('{t, mk_exp(1, 32'h40, 32'd12, 4'b0000, 32'h1234, 5'd0, 0, 0, 3'b010, 0)});
      // Illegal opcode: a/b zero, regwrite and branch off, side data rides along.
      vecs.push_back('{mk_in(BAD, 3'b011, 1'b1, 32'h300, 32'h77, 5'd1, 32'd3, 5'd2, 32'd8, 5'd5),
                       mk_exp(1, 32'd0, 32'd0, 4'b0000, 32'd8, 5'd5, 0, 0, 3'b011, 1)});
      // id_valid = 0 loads a bubble.
      t = mk_in(OP, 3'b000, 1'b1, 32'h0, 32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
      t.valid = 1'b0;
      vecs.push_back('{t, zero_e});

      for (int k = 0; k < vecs.size(); k++) begin
         apply(vecs[k].i);
         check_all($sformatf("vec%0d", k), vecs[k].e);
      end

      // ---- stall holds for 3 cycles while inputs change ----
      apply(mk_in(OP, 3'b000, 1'b0, 32'h0, 32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3));
      check_all("pre_stall", mk_exp(1, 32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1, 0, 3'b000, 0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         stall = 1'b1;
         drive(mk_in(BR, 3'b111, 1'b1, 32'h44, 32'h9, 5'd6, 32'd60 + k, 5'd7, 32'd70, 5'd8));
         @(posedge clk);
         #1;
         check_all($sformatf("stall%0d", k),
                   mk_exp(1, 32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1, 0, 3'b000, 0));
      end

      // ---- stall and flush together: flush wins ----
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check_all("stall_flush", zero_e);
      @(negedge clk);
      stall = 1'b0; flush = 1'b0;

      // ---- flush alone after a real load ----
      apply(mk_in(OP, 3'b100, 1'b0, 32'h0, 32'h0, 5'd1, 32'hF0, 5'd2, 32'h0F, 5'd9));
      check_all("pre_flush", mk_exp(1, 32'hF0, 32'h0F, 4'b0100, 32'h0F, 5'd9, 1, 0, 3'b100, 0));
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      check_all("flush", zero_e);
      @(negedge clk);
      flush = 1'b0;

      // ---- async reset mid-stall, between edges ----
      apply(mk_in(OP, 3'b000, 1'b1, 32'h0, 32'h0, 5'd1, 32'd30, 5'd2, 32'd10, 5'd4));
      check_all("pre_reset", mk_exp(1, 32'd30, 32'd10, 4'b1000, 32'd10, 5'd4, 1, 0, 3'b000, 0));
      @(negedge clk);
      stall = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      check_all("async_reset", zero_e);
      @(negedge clk);
      reset = 1'b0; stall = 1'b0;

      // ---- first load after reset ----
      apply(mk_in(OP, 3'b000, 1'b0, 32'h0, 32'h0, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3));
      check_all("post_reset", mk_exp(1, 32'd5, 32'd7, 4'b0000, 32'd7, 5'd3, 1, 0, 3'b000, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
